// File: rtl/xor_nn_seq.sv
// Sequential N_IN -> N_HID -> 1 fixed-point network on one shared MAC with hard-sigmoid activation.
// Optional macro XOR_NN_THRESH_EN adds a registered y_bit threshold output.
module xor_nn_seq #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int N_IN   = 2,
  parameter int N_HID  = 3,
  localparam int AW    = $clog2(N_HID*(N_IN+2)+1)
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DATA_W-1:0]   x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        y,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy
`ifdef XOR_NN_THRESH_EN
  , output logic                   y_bit
`endif
);

  localparam int ACC_W   = 2*DATA_W + $clog2(N_IN+N_HID+1);
  localparam int PW      = 2*DATA_W;
  localparam int HW      = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int IW      = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int B1_BASE = N_HID*N_IN;
  localparam int W2_BASE = N_HID*(N_IN+1);
  localparam int B2_ADDR = N_HID*(N_IN+2);

  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic signed [DATA_W:0]  HALF = (DATA_W+1)'(1 << (FRAC_W-1));
  localparam logic signed [DATA_W:0]  ONE  = (DATA_W+1)'(1 << FRAC_W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HMAC = 3'd2;
  localparam logic [2:0] S_HACT = 3'd3;
  localparam logic [2:0] S_OMAC = 3'd4;
  localparam logic [2:0] S_OACT = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // Saturate the accumulator to DATA_W, then 0.5 + z/4 clamped to [0, 1].
  function automatic logic signed [DATA_W-1:0] act(input logic signed [ACC_W-1:0] a);
    logic signed [DATA_W-1:0] z;
    logic signed [DATA_W:0]   t;
    if (a > SMAX)      z = SMAX[DATA_W-1:0];
    else if (a < SMIN) z = SMIN[DATA_W-1:0];
    else               z = a[DATA_W-1:0];
    t = (DATA_W+1)'(z >>> 2) + HALF;
    if (t[DATA_W])     return '0;
    else if (t > ONE)  return ONE[DATA_W-1:0];
    else               return t[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] w1_q [N_HID][N_IN];
  logic signed [DATA_W-1:0] b1_q [N_HID];
  logic signed [DATA_W-1:0] w2_q [N_HID];
  logic signed [DATA_W-1:0] b2_q;
  logic signed [DATA_W-1:0] a2_q [N_HID];
  logic signed [DATA_W-1:0] x_q  [N_IN];

  logic [2:0]               state_q, state_d;
  logic [HW-1:0]            h_q, h_d;
  logic [IW-1:0]            i_q, i_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     vld_q, vld_d;

  logic signed [DATA_W-1:0] opa, opb, act_out;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  term;
  logic                     accept;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_q;
  assign y         = y_q;

  // Single multiplier shared between the hidden and output layers.
  assign opa     = (state_q == S_OMAC) ? w2_q[h_q] : w1_q[h_q][i_q];
  assign opb     = (state_q == S_OMAC) ? a2_q[h_q] : x_q[i_q];
  assign prod    = PW'(opa) * PW'(opb);
  assign term    = ACC_W'(prod >>> FRAC_W);
  assign act_out = act(acc_q);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < N_HID; h++) begin
        for (int i = 0; i < N_IN; i++) w1_q[h][i] <= '0;
        b1_q[h] <= '0;
        w2_q[h] <= '0;
      end
      b2_q <= '0;
    end else if (wr_en && state_q == S_IDLE) begin
      for (int h = 0; h < N_HID; h++) begin
        for (int i = 0; i < N_IN; i++)
          if (wr_addr == AW'(h*N_IN+i)) w1_q[h][i] <= wr_data;
        if (wr_addr == AW'(B1_BASE+h)) b1_q[h] <= wr_data;
        if (wr_addr == AW'(W2_BASE+h)) w2_q[h] <= wr_data;
      end
      if (wr_addr == AW'(B2_ADDR)) b2_q <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    i_d     = i_q;
    acc_d   = acc_q;
    y_d     = y_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: begin
        h_d     = '0;
        i_d     = '0;
        acc_d   = ACC_W'(b1_q[0]);
        state_d = S_HMAC;
      end
      S_HMAC: begin
        acc_d = acc_q + term;
        if (i_q == IW'(N_IN-1)) state_d = S_HACT;
        else                    i_d     = i_q + IW'(1);
      end
      S_HACT: begin
        i_d = '0;
        if (h_q == HW'(N_HID-1)) begin
          h_d     = '0;
          acc_d   = ACC_W'(b2_q);
          state_d = S_OMAC;
        end else begin
          h_d     = h_q + HW'(1);
          acc_d   = ACC_W'(b1_q[h_q + HW'(1)]);
          state_d = S_HMAC;
        end
      end
      S_OMAC: begin
        acc_d = acc_q + term;
        if (h_q == HW'(N_HID-1)) state_d = S_OACT;
        else                     h_d     = h_q + HW'(1);
      end
      S_OACT: begin
        y_d     = act_out;
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) begin
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      for (int h = 0; h < N_HID; h++) a2_q[h] <= '0;
      for (int i = 0; i < N_IN; i++)  x_q[i]  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      if (accept)
        for (int i = 0; i < N_IN; i++) x_q[i] <= x[i*DATA_W +: DATA_W];
      if (state_q == S_HACT) a2_q[h_q] <= act_out;
    end
  end

`ifdef XOR_NN_THRESH_EN
  logic y_bit_q;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                 y_bit_q <= 1'b0;
    else if (state_q == S_OACT) y_bit_q <= (act_out >= DATA_W'(1 << (FRAC_W-1)));
  end
  assign y_bit = y_bit_q;
`endif

endmodule
